friscv_axi_ram_responder: RTL

// AXI4 responder (slave) memory serving the data-cache memory-side master
// (dcache_aw/w/b/ar/r channels). It stores full-width AXI_DATA_W cache blocks
// and services INCR bursts. One write burst and one read burst are in flight
// at a time; the two channels run independently. It is the memory end of the

---
 rtl/friscv_axi_ram_responder_if.sv | 54 +++++
 rtl/friscv_axi_ram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/friscv_axi_ram_responder_if.sv
// AXI4 channel bundle between the dcache memory-side master and the RAM responder.
interface friscv_axi_ram_responder_if #(
   parameter int AXI_ADDR_W = 8,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 128
);
   logic                    awvalid;
   logic                    awready;
   logic [AXI_ADDR_W-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [1:0]              awburst;
   logic [AXI_ID_W-1:0]     awid;
   logic                    wvalid;
   logic                    wready;
   logic                    wlast;
   logic [AXI_DATA_W-1:0]   wdata;
   logic [AXI_DATA_W/8-1:0] wstrb;
   logic                    bvalid;
   logic                    bready;
   logic [AXI_ID_W-1:0]     bid;
   logic [1:0]              bresp;
   logic                    arvalid;
   logic                    arready;
   logic [AXI_ADDR_W-1:0]   araddr;
   logic [7:0]              arlen;
   logic [1:0]              arburst;
   logic [AXI_ID_W-1:0]     arid;
   logic                    rvalid;
   logic                    rready;
   logic [AXI_ID_W-1:0]     rid;
   logic [1:0]              rresp;
   logic [AXI_DATA_W-1:0]   rdata;
   logic                    rlast;

   modport master (
      output awvalid, awaddr, awlen, awburst, awid,
      output wvalid, wlast, wdata, wstrb,
      output bready,
      output arvalid, araddr, arlen, arburst, arid,
      output rready,
      input  awready, wready, bvalid, bid, bresp,
      input  arready, rvalid, rid, rresp, rdata, rlast
   );

   modport slave (
      input  awvalid, awaddr, awlen, awburst, awid,
      input  wvalid, wlast, wdata, wstrb,
      input  bready,
      input  arvalid, araddr, arlen, arburst, arid,
      input  rready,
      output awready, wready, bvalid, bid, bresp,
      output arready, rvalid, rid, rresp, rdata, rlast
   );
endinterface

// File: rtl/friscv_axi_ram_responder.sv
// AXI4 RAM responder for the dcache bus: independent write and read burst engines over a word array.
// Define FRISCV_AXI_RAM_ERR_EN to return SLVERR for non-INCR bursts and early wlast.
module friscv_axi_ram_responder #(
   parameter int AXI_ADDR_W = 8,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 128,
   parameter int RAM_DEPTH  = 16
) (
   input logic                        aclk,
   input logic                        srst,
   friscv_axi_ram_responder_if.slave  bus
);
   localparam int STRB_W = AXI_DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(RAM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   // Keeps both ready outputs low until the first edge with srst released.
   logic live;

   logic [IDX_W-1:0]      w_idx, r_idx;
   logic [7:0]            w_len, w_cnt, r_len, r_cnt;
   logic [AXI_ID_W-1:0]   w_id, r_id;
   logic [1:0]            w_resp, r_resp;
   logic                  w_bad_q;
   logic                  aw_hs, w_hs, ar_hs, r_hs;
   logic                  w_end, r_end;
   logic                  aw_bad, ar_bad, w_early;
   logic                  r_err, mem_we;
   logic                  unused_bits;
   logic [AXI_DATA_W-1:0] mem [RAM_DEPTH];

`ifdef FRISCV_AXI_RAM_ERR_EN
   assign aw_bad      = (bus.awburst != 2'b01);
   assign ar_bad      = (bus.arburst != 2'b01);
   assign w_early     = bus.wlast && (w_cnt != w_len);
   assign unused_bits = ^{bus.awaddr, bus.araddr};
`else
   assign aw_bad      = 1'b0;
   assign ar_bad      = 1'b0;
   assign w_early     = 1'b0;
   assign unused_bits = ^{bus.awaddr, bus.araddr, bus.awburst, bus.arburst};
`endif

   // Handshakes are decoded from state so they never loop through the ready outputs.
   assign aw_hs = bus.awvalid && live && (w_state == W_IDLE);
   assign w_hs  = bus.wvalid && (w_state == W_DATA);
   assign w_end = bus.wlast || (w_cnt == w_len);
   assign ar_hs = bus.arvalid && live && (r_state == R_IDLE);
   assign r_hs  = bus.rready && (r_state == R_DATA);
   assign r_end = (r_cnt == r_len);
   assign r_err = r_resp[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (srst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         live    <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
         live    <= 1'b1;
      end
   end

   // NOTE: every output and next-state variable gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = w_state;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            bus.awready = live;
            if (aw_hs) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            bus.wready = 1'b1;
            if (w_hs && w_end) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            if (bus.bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   assign bus.bid   = w_id;
   assign bus.bresp = w_resp;

   always_ff @(posedge aclk) begin
      if (srst) begin
         w_idx   <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_id    <= '0;
         w_resp  <= RESP_OKAY;
         w_bad_q <= 1'b0;
      end else if (aw_hs) begin
         w_idx   <= bus.awaddr[OFF_W +: IDX_W];
         w_len   <= bus.awlen;
         w_cnt   <= '0;
         w_id    <= bus.awid;
         w_resp  <= RESP_OKAY;
         w_bad_q <= aw_bad;
      end else if (w_hs) begin
         w_idx <= w_idx + 1'b1;
         w_cnt <= w_cnt + 8'd1;
         if (w_end) w_resp <= (w_bad_q || w_early) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // A rejected burst still consumes its beats but never touches the array.
   assign mem_we = w_hs && !w_bad_q && !srst;

   // NOTE: the array is intentionally not reset; contents survive srst like a real RAM.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      bus.rid     = '0;
      bus.rresp   = RESP_OKAY;
      bus.rdata   = '0;
      case (r_state)
         R_IDLE: begin
            bus.arready = live;
            if (ar_hs) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            bus.rvalid = 1'b1;
            bus.rlast  = r_end;
            bus.rid    = r_id;
            bus.rresp  = r_resp;
            // Asynchronous read: a same-cycle write lands on the next edge, so old data is returned.
            bus.rdata  = r_err ? '0 : mem[r_idx];
            if (r_hs && r_end) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         r_idx  <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_id   <= '0;
         r_resp <= RESP_OKAY;
      end else if (ar_hs) begin
         r_idx  <= bus.araddr[OFF_W +: IDX_W];
         r_len  <= bus.arlen;
         r_cnt  <= '0;
         r_id   <= bus.arid;
         r_resp <= ar_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
         r_idx <= r_idx + 1'b1;
         r_cnt <= r_cnt + 8'd1;
      end
   end
endmodule
